ultrasonic_echo_emulator: RTL

ULTRASONIC_ECHO_EMULATOR -- requirements
Module: ultrasonic_echo_emulator

---
 rtl/ultrasonic_pkg.sv | 40 ++++
 rtl/ultrasonic_echo_channel.sv | 131 +++++++++++++
 rtl/ultrasonic_echo_emulator.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic echo emulator: register map, channel
// state encoding, reset values and LFSR helpers.
package ultrasonic_pkg;

    localparam logic [5:0] REG_CTRL    = 6'h00;
    localparam logic [5:0] REG_STATUS  = 6'h01;
    localparam logic [5:0] REG_WIDTH_A = 6'h02;
    localparam logic [5:0] REG_WIDTH_B = 6'h03;
    localparam logic [5:0] REG_DELAY   = 6'h04;
    localparam logic [5:0] REG_COUNT   = 6'h05;
    localparam logic [5:0] REG_JMASK   = 6'h06;

    localparam logic [31:0] BAD_ADDR_DATA    = 32'hDEAD_BEEF;
    localparam logic [15:0] TRIG_MIN_DEFAULT = 16'd400;
    localparam logic [2:0]  CTRL_RST         = 3'b011;
    localparam logic [15:0] WIDTH_RST        = 16'h0100;
    localparam logic [15:0] DELAY_RST        = 16'h00C8;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask over state[15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRIG  = 2'd1,
        ST_DELAY = 2'd2,
        ST_ECHO  = 2'd3
    } ch_state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/ultrasonic_echo_channel.sv
// One emulated sensor channel: trigger synchronizer, trigger-width qualifier,
// delay/echo sequencing and a wrapping valid-trigger counter.
module echo_channel
    import ultrasonic_pkg::*;
#(
    parameter logic [15:0] TRIG_MIN    = TRIG_MIN_DEFAULT,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        trig_i,
    input  logic [15:0] width_i,
    input  logic [15:0] delay_i,
    output logic        echo_o,
    output logic        busy_o,
    output logic        err_set_o,
    output logic        done_set_o,
    output logic [15:0] cnt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   trig_prev_q;
    logic                   trig_s;
    logic                   rise;
    logic                   fall;

    ch_state_e   state_q, state_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] dcnt_q, dcnt_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [15:0] cnt_q, cnt_d;

    assign trig_s = sync_q[SYNC_STAGES-1];
    assign rise   = trig_s & ~trig_prev_q;
    assign fall   = ~trig_s & trig_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            trig_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= trig_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            trig_prev_q <= trig_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            dcnt_q  <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            dcnt_q  <= dcnt_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        dcnt_d     = dcnt_q;
        wcnt_d     = wcnt_q;
        cnt_d      = cnt_q;
        err_set_o  = 1'b0;
        done_set_o = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_TRIG;
                        hcnt_d  = 16'd1;
                    end
                end
                ST_TRIG: begin
                    if (fall) begin
                        if (hcnt_q >= TRIG_MIN) begin
                            // Width and delay are captured here so later writes
                            // cannot disturb the pulse already in flight.
                            state_d = ST_DELAY;
                            cnt_d   = cnt_q + 16'd1;
                            dcnt_d  = (delay_i == 16'd0) ? 16'd1 : delay_i;
                            wcnt_d  = width_i;
                        end else begin
                            state_d   = ST_IDLE;
                            err_set_o = 1'b1;
                        end
                    end else if (hcnt_q != 16'hFFFF) begin
                        hcnt_d = hcnt_q + 16'd1;
                    end
                end
                ST_DELAY: begin
                    if (dcnt_q == 16'd1) begin
                        if (wcnt_q == 16'd0) begin
                            state_d    = ST_IDLE;
                            done_set_o = 1'b1;
                        end else begin
                            state_d = ST_ECHO;
                        end
                    end else begin
                        dcnt_d = dcnt_q - 16'd1;
                    end
                end
                ST_ECHO: begin
                    if (wcnt_q == 16'd1) begin
                        state_d    = ST_IDLE;
                        done_set_o = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q - 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign echo_o = (state_q == ST_ECHO);
    assign busy_o = (state_q != ST_IDLE);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// Two-channel ultrasonic echo emulator with a Wishbone register slave.
// Define ULTRASONIC_ECHO_JITTER_EN to add LFSR-based echo width jitter.
module ultrasonic_echo_emulator
    import ultrasonic_pkg::*;
#(
    parameter logic [15:0] TRIG_MIN    = TRIG_MIN_DEFAULT,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        trig_a_i,
    input  logic        trig_b_i,
    output logic        echo_a_o,
    output logic        echo_b_o,
    output logic        irq
);

    logic        req;
    logic        wr;
    logic [5:0]  reg_idx;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rd_data;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] width_a_q, width_a_d;
    logic [15:0] width_b_q, width_b_d;
    logic [15:0] delay_q, delay_d;
    logic [3:0]  sticky_q, sticky_d;    // {done_b, done_a, err_b, err_a}
    logic [3:0]  sticky_clr;
    logic [3:0]  sticky_set;
    logic        irq_q, irq_d;
    logic [15:0] eff_width_a;
    logic [15:0] eff_width_b;
    logic [15:0] jmask_rd;
    logic        busy_a, busy_b;
    logic        err_set_a, err_set_b;
    logic        done_set_a, done_set_b;
    logic [15:0] cnt_a, cnt_b;
    logic        unused_bits;

    // The ~ack_q term keeps ack to a single cycle even if stb stays high.
    assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr      = req & wb_we_i;
    assign reg_idx = wb_adr_i[7:2];
    assign ack_d   = req;

    assign unused_bits = ^{wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i[31:16]};

`ifdef ULTRASONIC_ECHO_JITTER_EN
    logic [15:0] lfsr_q;
    logic [15:0] jmask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= LFSR_SEED;
            jmask_q <= '0;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
            if (wr && reg_idx == REG_JMASK) begin
                jmask_q <= wb_dat_i[15:0];
            end
        end
    end

    assign eff_width_a = sat_add16(width_a_q, lfsr_q & jmask_q);
    assign eff_width_b = sat_add16(width_b_q, lfsr_q & jmask_q);
    assign jmask_rd    = jmask_q;
`else
    assign eff_width_a = width_a_q;
    assign eff_width_b = width_b_q;
    assign jmask_rd    = 16'h0000;
`endif

    always_comb begin
        ctrl_d     = ctrl_q;
        width_a_d  = width_a_q;
        width_b_d  = width_b_q;
        delay_d    = delay_q;
        sticky_clr = 4'b0000;
        if (wr) begin
            case (reg_idx)
                REG_CTRL:    ctrl_d     = wb_dat_i[2:0];
                REG_STATUS:  sticky_clr = wb_dat_i[5:2];
                REG_WIDTH_A: width_a_d  = wb_dat_i[15:0];
                REG_WIDTH_B: width_b_d  = wb_dat_i[15:0];
                REG_DELAY:   delay_d    = wb_dat_i[15:0];
                default:     ;
            endcase
        end
    end

    // A set event in the same cycle as its write-1-to-clear takes priority.
    assign sticky_set = {done_set_b, done_set_a, err_set_b, err_set_a};
    assign sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;
    assign irq_d      = ctrl_q[2] & (|sticky_q);

    always_comb begin
        case (reg_idx)
            REG_CTRL:    rd_data = {29'd0, ctrl_q};
            REG_STATUS:  rd_data = {26'd0, sticky_q, busy_b, busy_a};
            REG_WIDTH_A: rd_data = {16'd0, width_a_q};
            REG_WIDTH_B: rd_data = {16'd0, width_b_q};
            REG_DELAY:   rd_data = {16'd0, delay_q};
            REG_COUNT:   rd_data = {cnt_b, cnt_a};
            REG_JMASK:   rd_data = {16'd0, jmask_rd};
            default:     rd_data = BAD_ADDR_DATA;
        endcase
    end

    assign dat_d = (req && !wb_we_i) ? rd_data : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            ctrl_q    <= CTRL_RST;
            width_a_q <= WIDTH_RST;
            width_b_q <= WIDTH_RST;
            delay_q   <= DELAY_RST;
            sticky_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            ctrl_q    <= ctrl_d;
            width_a_q <= width_a_d;
            width_b_q <= width_b_d;
            delay_q   <= delay_d;
            sticky_q  <= sticky_d;
            irq_q     <= irq_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign irq      = irq_q;

    echo_channel #(
        .TRIG_MIN    (TRIG_MIN),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ch_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (ctrl_q[0]),
        .trig_i     (trig_a_i),
        .width_i    (eff_width_a),
        .delay_i    (delay_q),
        .echo_o     (echo_a_o),
        .busy_o     (busy_a),
        .err_set_o  (err_set_a),
        .done_set_o (done_set_a),
        .cnt_o      (cnt_a)
    );

    echo_channel #(
        .TRIG_MIN    (TRIG_MIN),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ch_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (ctrl_q[1]),
        .trig_i     (trig_b_i),
        .width_i    (eff_width_b),
        .delay_i    (delay_q),
        .echo_o     (echo_b_o),
        .busy_o     (busy_b),
        .err_set_o  (err_set_b),
        .done_set_o (done_set_b),
        .cnt_o      (cnt_b)
    );

endmodule
